approx_mul_seq: RTL and testbench



---
 rtl/approx_mul_pkg.sv | 28 ++
 rtl/approx_mul_row.sv | 18 +
 rtl/approx_mul_seq.sv | 123 ++++++++++++
 tb/tb_approx_mul_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the iterative truncated shift-add multiplier.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the mask helper supports; results are cast down by callers.
  localparam int MAX_W = 64;

  function automatic int tw_of(input int w);
    return $clog2(2 * w + 1);
  endfunction

  // Column c survives when it lies inside the 2*w-bit product and c >= t.
  // A t beyond 2*w naturally yields an all-zero mask.
  function automatic logic [2*MAX_W-1:0] col_mask(input int w, input int t);
    logic [2*MAX_W-1:0] m;
    m = '0;
    for (int c = 0; c < 2 * MAX_W; c++) begin
      if (c < 2 * w && c >= t) m[c] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mul_row.sv
// One partial-product row: (a & {WIDTH{bk}}) << k, restricted to the kept columns.
module approx_mul_row #(
  parameter int WIDTH = 6,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               bk,
  input  logic [CW-1:0]      k,
  input  logic [2*WIDTH-1:0] mask,
  output logic [2*WIDTH-1:0] row
);

  logic [2*WIDTH-1:0] pp;

  assign pp  = {{WIDTH{1'b0}}, (a & {WIDTH{bk}})};
  assign row = (pp << k) & mask;

endmodule

// File: rtl/approx_mul_seq.sv
// Iterative approximate multiplier: one masked partial-product row per cycle,
// valid/ready on both sides. Define APPROX_MUL_ERR_EN to build the exact shadow
// accumulator and drive err_o; otherwise err_o is tied to zero.
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int TW    = tw_of(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [TW-1:0]      trunc_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p_o,
  output logic [2*WIDTH-1:0] err_o
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_nxt, row_apx;
  logic               last;
  logic               accept;

  assign mask_d  = (2*WIDTH)'(col_mask(WIDTH, int'(trunc_i)));
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign accept  = (state_q == IDLE) && in_valid;
  assign acc_nxt = acc_q + row_apx;
  assign p_o     = acc_q;

  approx_mul_row #(.WIDTH(WIDTH), .CW(CW)) u_row_apx (
    .a    (a_q),
    .bk   (b_q[cnt_q]),
    .k    (cnt_q),
    .mask (mask_q),
    .row  (row_apx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture on accept, accumulate one row per BUSY cycle, hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      a_q    <= a_i;
      b_q    <= b_i;
      mask_q <= mask_d;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef APPROX_MUL_ERR_EN
  logic [2*WIDTH-1:0] ex_q, ex_nxt, row_ex, err_q;

  assign ex_nxt = ex_q + row_ex;
  assign err_o  = err_q;

  approx_mul_row #(.WIDTH(WIDTH), .CW(CW)) u_row_ex (
    .a    (a_q),
    .bk   (b_q[cnt_q]),
    .k    (cnt_q),
    .mask ({(2*WIDTH){1'b1}}),
    .row  (row_ex)
  );

  // Error is latched on the same edge that lands the final approximate sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      err_q <= '0;
    end else if (accept) begin
      ex_q  <= '0;
      err_q <= '0;
    end else if (state_q == BUSY) begin
      ex_q <= ex_nxt;
      if (last) err_q <= ex_nxt - acc_nxt;
    end
  end
`else
  assign err_o = '0;
`endif

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed-vector bench for approx_mul_seq at WIDTH=6, plus stall, reset and random runs.
module tb_approx_mul_seq;

  localparam int W  = 6;
  localparam int TW = $clog2(2 * W + 1);
`ifdef APPROX_MUL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a_i, b_i;
  logic [TW-1:0]   trunc_i;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  p_o, err_o;

  approx_mul_seq #(.WIDTH(W), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .trunc_i   (trunc_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_o       (p_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int a;
    int b;
    int t;
    int p;
    int e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_p(input int a, input int b, input int t);
    int s;
    s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (i + j) >= t) s += (1 << (i + j));
    return s;
  endfunction

  // Issue one operation, wait (bounded) for its result, then hand it off.
  task automatic run_op(input int a, input int b, input int t,
                        output logic [2*W-1:0] p, output logic [2*W-1:0] e,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    a_i      = W'(a);
    b_i      = W'(b);
    trunc_i  = TW'(t);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i      = '1;
    b_i      = '1;
    trunc_i  = '0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = p_o;
    e = err_o;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic [2*W-1:0] p, e;
    int lat;
    int seen;

    vecs[0] = '{a: 63, b: 63, t: 0,  p: 3969, e: 0};
    vecs[1] = '{a: 63, b: 63, t: 6,  p: 3648, e: 321};
    vecs[2] = '{a: 5,  b: 3,  t: 2,  p: 12,   e: 3};
    vecs[3] = '{a: 1,  b: 1,  t: 1,  p: 0,    e: 1};
    vecs[4] = '{a: 63, b: 63, t: 15, p: 0,    e: 3969};
    vecs[5] = '{a: 63, b: 63, t: 12, p: 0,    e: 3969};
    vecs[6] = '{a: 0,  b: 45, t: 0,  p: 0,    e: 0};
    vecs[7] = '{a: 2,  b: 3,  t: 0,  p: 6,    e: 0};
    vecs[8] = '{a: 7,  b: 9,  t: 3,  p: 56,   e: 7};
    vecs[9] = '{a: 63, b: 1,  t: 5,  p: 32,   e: 31};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_i       = '0;
    b_i       = '0;
    trunc_i   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_p",         p_o,       0);
    check("rst_err",       err_o,     0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].t, p, e, lat);
      check($sformatf("vec%0d_lat", i), lat, W);
      check($sformatf("vec%0d_p", i),   p,   vecs[i].p);
      check($sformatf("vec%0d_err", i), e,   ERR_EN ? vecs[i].e : 0);
    end

    // Backpressure: hold the result for 5 cycles with a stray in_valid pulse.
    @(negedge clk);
    in_valid = 1'b1; a_i = 6'd63; b_i = 6'd63; trunc_i = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("stall_lat", lat, W);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        in_valid = 1'b1; a_i = 6'd1; b_i = 6'd1; trunc_i = 4'd0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_p", i),     p_o,       3648);
      check($sformatf("stall%0d_err", i),   err_o,     ERR_EN ? 321 : 0);
      check($sformatf("stall%0d_ready", i), in_ready,  0);
      check($sformatf("stall%0d_valid", i), out_valid, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handoff_in_ready",  in_ready,  1);
    check("handoff_out_valid", out_valid, 0);
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk);
      #1;
      seen = seen | int'(out_valid);
    end
    check("stall_pulse_ignored", seen, 0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    in_valid = 1'b1; a_i = 6'd63; b_i = 6'd63; trunc_i = 4'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready",  in_ready,  1);
    check("abort_p",         p_o,       0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2, 3, 0, p, e, lat);
    check("after_abort_lat", lat, W);
    check("after_abort_p",   p,   6);
    check("after_abort_err", e,   0);

    for (int i = 0; i < 200; i++) begin
      int ra, rb, rt, rp;
      ra = int'($urandom_range(0, 63));
      rb = int'($urandom_range(0, 63));
      rt = int'($urandom_range(0, 15));
      rp = ref_p(ra, rb, rt);
      run_op(ra, rb, rt, p, e, lat);
      check($sformatf("rnd%0d_p a=%0d b=%0d t=%0d", i, ra, rb, rt), p, rp);
      check($sformatf("rnd%0d_err", i), e, ERR_EN ? (ra * rb - rp) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
